hex_display_scheduler: RTL and testbench
========================================

# hex_display_scheduler

Time-shares one combinational 7-segment decoder across a bank of `DIGITS` common-anode displays on the DE1-SoC. It takes a 32-bit debug value (PC, register, ALU result) through a load handshake and feeds its nibbles one per cycle to the shared decoder. It captures the decoded segments into per-digit registers. When the value does not fit on the available digits, it pages between the low and high nibbles with a programmable dwell time.

## Interface
Parameters:
- `DIGITS`, 6: number of physical displays; legal range 1..8.
- `HOLD_CYCLES`, 50_000_000: page dwell time in clock cycles; must be ≥1.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `value_i` input 32: value to display.
- `load_i` input 1: load request; sampled only when `busy_o`=0.
- `busy_o` output 1: high while a scan is in progress.
- `nibble_o` output 4: registered nibble driven to the shared decoder's binary input.
- `seg_i` input 7: decoder segment output (gfedcba, active-low), combinational from `nibble_o`.
- `hex_o` output 7*DIGITS: digit k occupies bits [7k+6:7k], active-low.
- `page_o` output 1: 0 = low page shown, 1 = high page shown.

## Operation
- Internal state:
  - `val_q` (32 b).
  - `idx` (3 b).
  - dwell counter sized for `HOLD_CYCLES`.
  - `page_o`.
  - FSM {IDLE, SCAN, HOLD}.
- Reset values:
  - `hex_o` all ones (all digits blank).
  - `busy_o`=0, `nibble_o`=0, `page_o`=0.
  - `val_q`=0, `idx`=0, counter=0, FSM=IDLE.
- Paging:
  - Paging is needed iff `DIGITS`<8 and `val_q[31:4*DIGITS]`≠0.
  - Page 0: digit k shows nibble k.
  - Page 1: digit k shows nibble DIGITS+k if DIGITS+k<8; otherwise the digit is blank (7'h7F written, decoder output ignored).
- IDLE:
  - `load_i`=1 → `val_q`←`value_i`, `page_o`←0, `idx`←0, go to SCAN.
- SCAN (`busy_o`=1):
  - Each cycle, `nibble_o` holds the nibble for digit `idx` on the current page.
  - At the clock edge, digit `idx` register ← `seg_i` (or blank, see page rules), then `idx`++.
  - After digit DIGITS-1: go to HOLD if paging is needed, otherwise IDLE.
  - `load_i` is ignored during SCAN.
- HOLD (`busy_o`=0):
  - Counter increments each cycle.
  - When it reaches HOLD_CYCLES-1: toggle `page_o`, clear the counter, `idx`←0, go to SCAN.
  - `load_i`=1 in HOLD takes priority over counter expiry: capture the new value, `page_o`←0, counter←0, go to SCAN.
- Digits not yet rewritten during a scan keep their previous contents. Per-digit update is acceptable at these rates.
- Asserting `rst_n` mid-scan or mid-hold blanks all digits immediately and returns the FSM to IDLE.

## Timing
- `load_i` sampled high at edge N:
  - `busy_o`=1 and `nibble_o`=nibble 0 after edge N.
  - Digit k is written at edge N+1+k.
  - `busy_o` falls after edge N+DIGITS.
- Scan latency is DIGITS cycles per page.
- In HOLD, the page toggle occurs HOLD_CYCLES cycles after HOLD entry, and the rescan starts on the same edge.
- `seg_i` must settle within one cycle of `nibble_o`. No combinational path exists from `seg_i` to any output.

## Configuration
- `HEX_LEADING_ZERO_BLANK_EN` defined:
  - On page 0, digits above the most significant nonzero nibble of `val_q[4*DIGITS-1:0]` are written blank.
  - Digit 0 is always shown, so a zero value shows a single "0".
  - Page 1 is unaffected.
- Not defined: every page-0 digit shows its decoded nibble, including leading zeros.

## Test plan
- Reset: hold `rst_n`=0 → `hex_o` = all ones, `busy_o`=0, `page_o`=0; release with `load_i`=0 → no change.
- Load 32'h0012_3456, DIGITS=6, macro off:
  - `busy_o` high for exactly 6 cycles.
  - `hex_o` digits 0..5 = 6,5,4,3,2,1 encodings (0000010, 0010010, 0011001, 0110000, 0100100, 1111001).
  - FSM returns to IDLE.
- Load 32'hAB00_00CD, HOLD_CYCLES=4:
  - Page 0 shows D,C,0,0,0,0.
  - After 4 HOLD cycles, `page_o`=1 and the display shows B,A then four blanks.
  - After a further 4 cycles, `page_o` returns to 0.
- `load_i` pulsed during SCAN is ignored. `load_i` in HOLD on the exact expiry cycle captures the new value and keeps `page_o`=0.
- With `HEX_LEADING_ZERO_BLANK_EN`:
  - Load 32'h0000_0000 → digit 0 = 1000000, digits 1..5 blank.
  - Load 32'h0000_0A00 → digits 3..5 blank.
- Assert `rst_n` low during digit 3 of a scan → all digits blank and `busy_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - shares one 7-seg decoder across DIGITS displays with paging.
// Optional feature macro: HEX_LEADING_ZERO_BLANK_EN (blank page-0 leading zeros).
module hex_display_scheduler #(
    parameter int DIGITS      = 6,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           value_i,
    input  logic                  load_i,
    output logic                  busy_o,
    output logic [3:0]            nibble_o,
    input  logic [6:0]            seg_i,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic                  page_o
);

    localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0]      LAST_IDX  = 3'(DIGITS - 1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t                r_state;
    logic [31:0]           r_val;
    logic [2:0]            r_idx;
    logic [CW-1:0]         r_cnt;
    logic                  r_page;
    logic                  r_busy;
    logic [3:0]            r_nibble;
    logic [7*DIGITS-1:0]   r_hex;

    logic                  w_need_page;
    logic                  w_lz_blank;
    logic                  w_blank;
    logic [6:0]            w_digit_seg;
    logic [2:0]            w_next_idx;

    // Nibble feeding digit idx on the given page; out-of-range high-page digits read as 0.
    function automatic logic [3:0] f_nibble(input logic [31:0] val, input logic page,
                                            input logic [2:0] idx);
        int          pos;
        logic [31:0] sh;
        pos = page ? DIGITS + int'(idx) : int'(idx);
        sh  = val >> (4 * pos);
        if (pos < 8)
            return sh[3:0];
        return 4'h0;
    endfunction

    generate
        if (DIGITS < 8) begin : g_page
            assign w_need_page = |r_val[31:4*DIGITS];
        end else begin : g_nopage
            assign w_need_page = 1'b0;
        end
    endgenerate

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [2:0] w_top;

    always_comb begin
        w_top = 3'd0;
        for (int k = 1; k < DIGITS; k++) begin
            if (r_val[4*k +: 4] != 4'h0)
                w_top = 3'(k);
        end
    end

    assign w_lz_blank = (r_idx > w_top);
`else
    assign w_lz_blank = 1'b0;
`endif

    assign w_blank     = r_page ? (DIGITS + int'(r_idx) >= 8) : w_lz_blank;
    assign w_digit_seg = w_blank ? 7'h7F : seg_i;
    assign w_next_idx  = r_idx + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_val    <= 32'h0;
            r_idx    <= 3'd0;
            r_cnt    <= '0;
            r_page   <= 1'b0;
            r_busy   <= 1'b0;
            r_nibble <= 4'h0;
            r_hex    <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_i) begin
                        r_val    <= value_i;
                        r_page   <= 1'b0;
                        r_idx    <= 3'd0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_nibble <= value_i[3:0];
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (r_idx == 3'(k))
                            r_hex[7*k +: 7] <= w_digit_seg;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= 3'd0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= w_need_page ? S_HOLD : S_IDLE;
                    end else begin
                        r_idx    <= w_next_idx;
                        r_nibble <= f_nibble(r_val, r_page, w_next_idx);
                    end
                end
                S_HOLD: begin
                    // A new load wins over a page flip landing on the same cycle.
                    if (load_i) begin
                        r_val    <= value_i;
                        r_page   <= 1'b0;
                        r_idx    <= 3'd0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_nibble <= value_i[3:0];
                        r_state  <= S_SCAN;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_page   <= ~r_page;
                        r_cnt    <= '0;
                        r_idx    <= 3'd0;
                        r_busy   <= 1'b1;
                        r_nibble <= f_nibble(r_val, ~r_page, 3'd0);
                        r_state  <= S_SCAN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign nibble_o = r_nibble;
    assign hex_o    = r_hex;
    assign page_o   = r_page;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed self-checking bench for hex_display_scheduler.
module tb_hex_display_scheduler;

    localparam int DIGITS = 6;
    localparam int HOLD   = 4;

    logic                clk;
    logic                rst_n;
    logic [31:0]         value_i;
    logic                load_i;
    logic                busy_o;
    logic [3:0]          nibble_o;
    logic [6:0]          seg_i;
    logic [7*DIGITS-1:0] hex_o;
    logic                page_o;

    int tests;
    int fails;

    hex_display_scheduler #(.DIGITS(DIGITS), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_i  (value_i),
        .load_i   (load_i),
        .busy_o   (busy_o),
        .nibble_o (nibble_o),
        .seg_i    (seg_i),
        .hex_o    (hex_o),
        .page_o   (page_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-low gfedcba decoder standing in for the board's shared decoder.
    always_comb begin
        case (nibble_o)
            4'h0: seg_i = 7'h40;  4'h1: seg_i = 7'h79;  4'h2: seg_i = 7'h24;  4'h3: seg_i = 7'h30;
            4'h4: seg_i = 7'h19;  4'h5: seg_i = 7'h12;  4'h6: seg_i = 7'h02;  4'h7: seg_i = 7'h78;
            4'h8: seg_i = 7'h00;  4'h9: seg_i = 7'h10;  4'hA: seg_i = 7'h08;  4'hB: seg_i = 7'h03;
            4'hC: seg_i = 7'h46;  4'hD: seg_i = 7'h21;  4'hE: seg_i = 7'h06;  default: seg_i = 7'h0E;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        value_i = v;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_i = 1'b0; value_i = 32'h0;
        #12;
        tests++; if (hex_o !== {7*DIGITS{1'b1}}) begin fails++; $display("FAIL reset_hex: got %h expected all ones", hex_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        tests++; if (page_o !== 1'b0) begin fails++; $display("FAIL reset_page: got %b expected 0", page_o); end
        tests++; if (nibble_o !== 4'h0) begin fails++; $display("FAIL reset_nibble: got %h expected 0", nibble_o); end
        rst_n = 1'b1;
        tick(); tick();
        tests++; if (hex_o !== {7*DIGITS{1'b1}} || busy_o !== 1'b0) begin
            fails++; $display("FAIL reset_release: hex %h busy %b expected all ones / 0", hex_o, busy_o);
        end
    endtask

    task automatic test_load_basic();
        int n;
        do_load(32'h0012_3456);
        tests++; if (busy_o !== 1'b1 || nibble_o !== 4'h6) begin
            fails++; $display("FAIL basic_first: busy %b nibble %h expected 1 / 6", busy_o, nibble_o);
        end
        count_busy(n);
        tests++; if (n != 6) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 6", n); end
        tests++; if (hex_o !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            fails++; $display("FAIL basic_hex: got %h expected %h", hex_o, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        end
        repeat (6) tick();
        tests++; if (busy_o !== 1'b0 || page_o !== 1'b0) begin
            fails++; $display("FAIL basic_idle: busy %b page %b expected 0 / 0", busy_o, page_o);
        end
    endtask

    task automatic test_paging();
        int n;
        do_load(32'hAB00_00CD);
        count_busy(n);
        tests++; if (hex_o !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h46, 7'h21}) begin
            fails++; $display("FAIL page0_hex: got %h expected %h", hex_o, {7'h40, 7'h40, 7'h40, 7'h40, 7'h46, 7'h21});
        end
        repeat (3) tick();
        tests++; if (page_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL hold_early: page %b busy %b expected 0 / 0", page_o, busy_o);
        end
        tick();
        tests++; if (page_o !== 1'b1 || busy_o !== 1'b1 || nibble_o !== 4'hB) begin
            fails++; $display("FAIL page1_start: page %b busy %b nibble %h expected 1 / 1 / B", page_o, busy_o, nibble_o);
        end
        count_busy(n);
        tests++; if (n != 6) begin fails++; $display("FAIL page1_busy_cycles: got %0d expected 6", n); end
        tests++; if (hex_o !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03}) begin
            fails++; $display("FAIL page1_hex: got %h expected %h", hex_o, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03});
        end
        repeat (4) tick();
        tests++; if (page_o !== 1'b0 || nibble_o !== 4'hD) begin
            fails++; $display("FAIL page0_return: page %b nibble %h expected 0 / D", page_o, nibble_o);
        end
        count_busy(n);
    endtask

    task automatic test_hold_load();
        int n;
        repeat (3) tick();
        do_load(32'h0000_0789);
        tests++; if (page_o !== 1'b0 || busy_o !== 1'b1 || nibble_o !== 4'h9) begin
            fails++; $display("FAIL hold_load: page %b busy %b nibble %h expected 0 / 1 / 9", page_o, busy_o, nibble_o);
        end
        count_busy(n);
        tests++; if (hex_o !== {7'h40, 7'h40, 7'h40, 7'h78, 7'h00, 7'h10}) begin
            fails++; $display("FAIL hold_load_hex: got %h expected %h", hex_o, {7'h40, 7'h40, 7'h40, 7'h78, 7'h00, 7'h10});
        end
        repeat (6) tick();
        tests++; if (busy_o !== 1'b0 || page_o !== 1'b0) begin
            fails++; $display("FAIL hold_load_idle: busy %b page %b expected 0 / 0", busy_o, page_o);
        end
    endtask

    task automatic test_scan_ignore_load();
        int n;
        do_load(32'h0000_0021);
        value_i = 32'hFFFF_FFFF;
        load_i  = 1'b1;
        tick();
        load_i  = 1'b0;
        value_i = 32'h0;
        count_busy(n);
        tests++; if (n != 5) begin fails++; $display("FAIL ignore_busy_cycles: got %0d expected 5", n + 1); end
        tests++; if (hex_o !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79}) begin
            fails++; $display("FAIL ignore_hex: got %h expected %h", hex_o, {7'h40, 7'h40, 7'h40, 7'h40, 7'h24, 7'h79});
        end
        repeat (6) tick();
        tests++; if (busy_o !== 1'b0 || page_o !== 1'b0) begin
            fails++; $display("FAIL ignore_idle: busy %b page %b expected 0 / 0", busy_o, page_o);
        end
    endtask

    task automatic test_leading_zero();
        int n;
        logic [7*DIGITS-1:0] exp_zero;
        logic [7*DIGITS-1:0] exp_a00;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        exp_zero = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        exp_a00  = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40};
`else
        exp_zero = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        exp_a00  = {7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h40};
`endif
        do_load(32'h0000_0000);
        count_busy(n);
        tests++; if (hex_o !== exp_zero) begin fails++; $display("FAIL lz_zero: got %h expected %h", hex_o, exp_zero); end
        do_load(32'h0000_0A00);
        count_busy(n);
        tests++; if (hex_o !== exp_a00) begin fails++; $display("FAIL lz_a00: got %h expected %h", hex_o, exp_a00); end
    endtask

    task automatic test_reset_midscan();
        do_load(32'h0012_3456);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (hex_o !== {7*DIGITS{1'b1}} || busy_o !== 1'b0) begin
            fails++; $display("FAIL midscan_reset: hex %h busy %b expected all ones / 0", hex_o, busy_o);
        end
        #2 rst_n = 1'b1;
        tick();
        tests++; if (hex_o !== {7*DIGITS{1'b1}} || busy_o !== 1'b0 || page_o !== 1'b0) begin
            fails++; $display("FAIL midscan_after: hex %h busy %b page %b expected all ones / 0 / 0", hex_o, busy_o, page_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_load_basic();
        test_paging();
        test_hold_load();
        test_scan_ignore_load();
        test_leading_zero();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
